// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide engine.
// The opcodes here are also the ones the EX-stage decoder drives.
package md_pkg;

  localparam int unsigned MdIterDefault = 32;

  localparam logic [4:0] MduNop   = 5'd0;
  localparam logic [4:0] MduMult  = 5'd1;
  localparam logic [4:0] MduMultu = 5'd2;
  localparam logic [4:0] MduDiv   = 5'd3;
  localparam logic [4:0] MduDivu  = 5'd4;
  localparam logic [4:0] MduMthi  = 5'd5;
  localparam logic [4:0] MduMtlo  = 5'd6;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } md_state_e;

  function automatic logic is_md_launch(input logic [4:0] op);
    return (op == MduMult) || (op == MduMultu) || (op == MduDiv) || (op == MduDivu);
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/md_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
// Multiply layout: {partial product, remaining multiplier}; divide: {remainder, dividend/quotient}.
module md_step (
  input  logic        is_div,
  input  logic [63:0] work,
  input  logic [31:0] mcand,
  input  logic [31:0] divisor,
  output logic [63:0] work_next
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic        ge;

  always_comb begin
    sum     = {1'b0, work[63:32]} + (work[0] ? {1'b0, mcand} : 33'd0);
    shifted = {work[63:32], work[31]};
    ge      = shifted >= {1'b0, divisor};
    if (is_div) begin
      // A successful subtract leaves a value below the divisor, so 32 bits hold it.
      work_next = {(ge ? (shifted[31:0] - divisor) : shifted[31:0]), work[30:0], ge};
    end else begin
      work_next = {sum, work[31:1]};
    end
  end

endmodule

// File: rtl/md_engine.sv
// Iterative multiply/divide unit owning HI/LO; Busy stalls the pipeline while it runs.
module md_engine
  import md_pkg::*;
#(
  parameter int unsigned ITER = MdIterDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Start,
  input  logic [4:0]  MDUOp,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        Busy
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic            div_q, div_d, zero_q, zero_d;
  logic [63:0]     work_q, work_d, work_step, prod_fix;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            launch, signed_op, sa, sb, is_div_op;
  logic [31:0]     a_abs, b_abs;

  md_step u_step (
    .is_div   (div_q),
    .work     (work_q),
    .mcand    (a_q),
    .divisor  (b_q),
    .work_next(work_step)
  );

  assign launch = Start && is_md_launch(MDUOp);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div_d    = div_q;
    zero_d   = zero_q;
    work_d   = work_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    signed_op = (MDUOp == MduMult) || (MDUOp == MduDiv);
    is_div_op = (MDUOp == MduDiv) || (MDUOp == MduDivu);
    sa        = signed_op & A[31];
    sb        = signed_op & B[31];
    a_abs     = sa ? neg32(A) : A;
    b_abs     = sb ? neg32(B) : B;
    prod_fix  = (sign_a_q ^ sign_b_q) ? (~work_q + 64'd1) : work_q;

    unique case (state_q)
      StIdle: begin
        if (launch) begin
          a_d      = a_abs;
          b_d      = b_abs;
          sign_a_d = sa;
          sign_b_d = sb;
          div_d    = is_div_op;
          zero_d   = (B == 32'd0);
          work_d   = is_div_op ? {32'd0, a_abs} : {32'd0, b_abs};
          cnt_d    = CntW'(ITER - 1);
          state_d  = StRun;
        end else if (!Start && MDUOp == MduMthi) begin
          hi_d = A;
        end else if (!Start && MDUOp == MduMtlo) begin
          lo_d = A;
        end
      end
      StRun: begin
        work_d = work_step;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFix: begin
        if (!div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (!zero_q) begin
          // Quotient sign follows sign mismatch; remainder sign follows the dividend.
          lo_d = (sign_a_q ^ sign_b_q) ? neg32(work_q[31:0]) : work_q[31:0];
          hi_d = sign_a_q ? neg32(work_q[63:32]) : work_q[63:32];
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div_q    <= 1'b0;
      zero_q   <= 1'b0;
      work_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div_q    <= div_d;
      zero_q   <= zero_d;
      work_q   <= work_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign Busy = launch || (state_q != StIdle);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_engine.sv
// Directed bench for md_engine: vector table plus hand sequences for timing corners.
module tb_md_engine;
  import md_pkg::*;

  localparam int ExpBusy = 34;

  logic        clk;
  logic        reset;
  logic [31:0] A, B;
  logic        Start;
  logic [4:0]  MDUOp;
  logic [31:0] hi, lo;
  logic        Busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs [12];

  md_engine #(.ITER(32)) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .Start(Start),
    .MDUOp(MDUOp),
    .hi   (hi),
    .lo   (lo),
    .Busy (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_hilo(input logic [4:0] op, input logic [31:0] v);
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = op; A = v;
    @(posedge clk); #1;
    MDUOp = MduNop;
  endtask

  // Launch in cycle 0; returns at the sampling point of the first cycle with Busy low.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int intr, output int nbusy, output int touched);
    logic [31:0] hi0, lo0;
    @(posedge clk); #1;
    Start = 1'b1; MDUOp = op; A = a; B = b;
    nbusy = 0;
    touched = 0;
    @(negedge clk);
    hi0 = hi;
    lo0 = lo;
    if (Busy) nbusy++;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (c == intr) begin
        Start = 1'b1; MDUOp = MduMultu; A = 32'd2; B = 32'd2;
      end else begin
        Start = 1'b0; MDUOp = MduNop; A = $urandom; B = $urandom;
      end
      @(negedge clk);
      if (!Busy) break;
      nbusy++;
      if (hi !== hi0 || lo !== lo0) touched++;
    end
  endtask

  initial begin
    int nb, tc, stray;

    vecs[0]  = '{MduMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{MduMult,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{MduDiv,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{MduDivu,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4]  = '{MduMult,  32'd6,         32'd7,         32'd0,         32'd42};
    vecs[5]  = '{MduDiv,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[6]  = '{MduMultu, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780};
    vecs[7]  = '{MduDivu,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
    vecs[8]  = '{MduMult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[9]  = '{MduDiv,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2};
    vecs[10] = '{MduMult,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1};
    vecs[11] = '{MduDivu,  32'd5,         32'd9,         32'd5,         32'd0};

    reset = 1'b0; Start = 1'b0; MDUOp = MduNop; A = '0; B = '0;
    @(negedge clk);
    check("reset_busy", {63'd0, Busy}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    write_hilo(MduMthi, 32'h0000_AAAA);
    write_hilo(MduMtlo, 32'h0000_5555);
    @(negedge clk);
    check("mthi", {32'd0, hi}, 64'h0000_AAAA);
    check("mtlo", {32'd0, lo}, 64'h0000_5555);

    // Start with a non-mult/div op must not stall or write anything.
    @(posedge clk); #1;
    Start = 1'b1; MDUOp = MduMthi; A = 32'hDEAD_BEEF;
    @(negedge clk);
    check("start_mthi_busy", {63'd0, Busy}, 64'd0);
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = MduNop;
    @(negedge clk);
    check("start_mthi_hi", {32'd0, hi}, 64'h0000_AAAA);
    check("start_mthi_idle", {63'd0, Busy}, 64'd0);

    run_op(MduDivu, 32'd1234, 32'd0, -1, nb, tc);
    check("div0_busy", 64'(nb), 64'(ExpBusy));
    check("div0_hi", {32'd0, hi}, 64'h0000_AAAA);
    check("div0_lo", {32'd0, lo}, 64'h0000_5555);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, nb, tc);
      check($sformatf("vec%0d_busy", i), 64'(nb), 64'(ExpBusy));
      check($sformatf("vec%0d_untouched", i), 64'(tc), 64'd0);
      check($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].exp_hi});
      check($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].exp_lo});
    end

    // Most-negative / -1, then MTLO in the very cycle Busy falls.
    run_op(MduDiv, 32'h8000_0000, 32'hFFFF_FFFF, -1, nb, tc);
    check("ovf_busy", 64'(nb), 64'(ExpBusy));
    check("ovf_lo", {32'd0, lo}, 64'h8000_0000);
    check("ovf_hi", {32'd0, hi}, 64'd0);
    Start = 1'b0; MDUOp = MduMtlo; A = 32'd7;
    @(posedge clk); #1;
    MDUOp = MduNop;
    @(negedge clk);
    check("mtlo_after_retire", {32'd0, lo}, 64'd7);
    check("mtlo_after_retire_busy", {63'd0, Busy}, 64'd0);

    // Second Start in cycle 10 of a running divide is dropped.
    run_op(MduDivu, 32'd100, 32'd7, 10, nb, tc);
    check("intr_busy", 64'(nb), 64'(ExpBusy));
    check("intr_lo", {32'd0, lo}, 64'd14);
    check("intr_hi", {32'd0, hi}, 64'd2);
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (Busy) stray++;
    end
    check("intr_quiet_busy", 64'(stray), 64'd0);
    check("intr_quiet_lo", {32'd0, lo}, 64'd14);
    check("intr_quiet_hi", {32'd0, hi}, 64'd2);

    // Reset in cycle 15 of MULT 6x7 clears everything at once.
    write_hilo(MduMthi, 32'h1111);
    write_hilo(MduMtlo, 32'h2222);
    @(posedge clk); #1;
    Start = 1'b1; MDUOp = MduMult; A = 32'd6; B = 32'd7;
    for (int c = 1; c < 15; c++) begin
      @(posedge clk); #1;
      Start = 1'b0; MDUOp = MduNop;
    end
    @(negedge clk);
    check("pre_reset_busy", {63'd0, Busy}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", {63'd0, Busy}, 64'd0);
    check("midreset_hi", {32'd0, hi}, 64'd0);
    check("midreset_lo", {32'd0, lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_busy", {63'd0, Busy}, 64'd0);

    run_op(MduMult, 32'd6, 32'd7, -1, nb, tc);
    check("relaunch_busy", 64'(nb), 64'(ExpBusy));
    check("relaunch_lo", {32'd0, lo}, 64'd42);
    check("relaunch_hi", {32'd0, hi}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
